// File: rtl/bp_fe_bp_pkg.sv
// Shared types and defaults for the gselect BHT update sequencer.
//   bp_bht_idx_width_gp  : BHT index width carried in each in-flight entry
//   bp_inflight_depth_gp : default number of in-flight branches
//   bp_inflight_entry_s  : {idx, pred} record kept per fetched branch
package bp_fe_bp_pkg;

  localparam int unsigned bp_bht_idx_width_gp = 10;
  localparam int unsigned bp_inflight_depth_gp = 8;

  typedef struct packed {
    logic [bp_bht_idx_width_gp-1:0] idx;
    logic                           pred;
  } bp_inflight_entry_s;

endpackage

// File: rtl/bp_fe_bp_inflight_fifo.sv
// In-order queue of in-flight branches awaiting backend resolution.
//   clk_i, reset_i : clock, synchronous active-high reset
//   clear_i        : empty the queue (applied after any same-cycle pop)
//   push_i, data_i : enqueue an entry (caller must not push while full)
//   pop_i, data_o  : dequeue the head entry; data_o is the current head
//   full_o, empty_o: occupancy flags
module bp_fe_bp_inflight_fifo
  import bp_fe_bp_pkg::*;
#(
  parameter int unsigned depth_p = bp_inflight_depth_gp
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clear_i,
  input  logic               push_i,
  input  bp_inflight_entry_s data_i,
  input  logic               pop_i,
  output bp_inflight_entry_s data_o,
  output logic               full_o,
  output logic               empty_o
);

  localparam int unsigned ptr_w_lp = $clog2(depth_p);
  localparam int unsigned cnt_w_lp = ptr_w_lp + 1;
  localparam logic [cnt_w_lp-1:0] depth_lp = cnt_w_lp'(depth_p);

  bp_inflight_entry_s mem_r [depth_p];
  logic [ptr_w_lp-1:0] wptr_r, rptr_r;
  logic [cnt_w_lp-1:0] count_r;

  assign data_o  = mem_r[rptr_r];
  assign full_o  = (count_r == depth_lp);
  assign empty_o = (count_r == '0);

  // Storage needs no reset: an entry is only read after it has been pushed.
  always_ff @(posedge clk_i) begin
    if (push_i && !full_o) begin
      mem_r[wptr_r] <= data_i;
    end
  end

  // The head is consumed combinationally by the caller in the pop cycle, so
  // a clear in that same cycle can simply zero the state afterwards.
  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
    end else begin
      if (push_i && !full_o) begin
        wptr_r <= wptr_r + ptr_w_lp'(1);
      end
      if (pop_i && !empty_o) begin
        rptr_r <= rptr_r + ptr_w_lp'(1);
      end
      unique case ({push_i && !full_o, pop_i && !empty_o})
        2'b10:   count_r <= count_r + cnt_w_lp'(1);
        2'b01:   count_r <= count_r - cnt_w_lp'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/bp_fe_bp_update_ctrl.sv
// Sequences the gselect BHT between fetch and backend resolution.
// Fetched branches issue a BHT read and are queued in order with their
// predicted direction; when the backend resolves the oldest branch a
// registered BHT write is issued with correct = (pred == taken).
//   clk_i, reset_i                      : clock, synchronous active-high reset
//   fetch_v_i, fetch_idx_i              : fetched branch and its BHT index
//   fetch_ready_o, fetch_taken_o        : accept / predicted direction
//   bp_r_v_o, bp_idx_r_o, bp_predict_i  : predictor read port
//   resolve_v_i, resolve_taken_i        : oldest branch resolved, actual dir
//   resolve_ready_o                     : a branch is in flight
//   flush_i                             : squash all in-flight entries
//   bp_w_v_o, bp_idx_w_o, bp_correct_o  : registered predictor write port
//   resolved_cnt_o, mispred_cnt_o       : saturating statistics counters
module bp_fe_bp_update_ctrl
  import bp_fe_bp_pkg::*;
#(
  parameter int unsigned bht_idx_width_p = bp_bht_idx_width_gp,
  parameter int unsigned depth_p         = bp_inflight_depth_gp,
  parameter int unsigned ctr_width_p     = 16
) (
  input  logic                       clk_i,
  input  logic                       reset_i,

  input  logic                       fetch_v_i,
  input  logic [bht_idx_width_p-1:0] fetch_idx_i,
  output logic                       fetch_ready_o,
  output logic                       fetch_taken_o,

  output logic                       bp_r_v_o,
  output logic [bht_idx_width_p-1:0] bp_idx_r_o,
  input  logic                       bp_predict_i,

  input  logic                       resolve_v_i,
  input  logic                       resolve_taken_i,
  output logic                       resolve_ready_o,

  input  logic                       flush_i,

  output logic                       bp_w_v_o,
  output logic [bht_idx_width_p-1:0] bp_idx_w_o,
  output logic                       bp_correct_o,

  output logic [ctr_width_p-1:0]     resolved_cnt_o,
  output logic [ctr_width_p-1:0]     mispred_cnt_o
);

  bp_inflight_entry_s push_entry, head_entry;
  logic full, empty, push, pop, correct;

  assign bp_r_v_o      = fetch_v_i;
  assign bp_idx_r_o    = fetch_idx_i;
  assign fetch_taken_o = bp_predict_i;

  assign fetch_ready_o   = !full && !flush_i;
  assign resolve_ready_o = !empty;

  assign push = fetch_v_i && fetch_ready_o;
  assign pop  = resolve_v_i && resolve_ready_o;

  always_comb begin
    push_entry      = '0;
    push_entry.idx  = bp_bht_idx_width_gp'(fetch_idx_i);
    push_entry.pred = bp_predict_i;
  end

  assign correct = (head_entry.pred == resolve_taken_i);

  bp_fe_bp_inflight_fifo #(
    .depth_p(depth_p)
  ) inflight_fifo (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .clear_i(flush_i),
    .push_i (push),
    .data_i (push_entry),
    .pop_i  (pop),
    .data_o (head_entry),
    .full_o (full),
    .empty_o(empty)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      bp_w_v_o     <= 1'b0;
      bp_idx_w_o   <= '0;
      bp_correct_o <= 1'b0;
    end else begin
      bp_w_v_o <= pop;
      if (pop) begin
        bp_idx_w_o   <= head_entry.idx[bht_idx_width_p-1:0];
        bp_correct_o <= correct;
      end
    end
  end

  // Counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      resolved_cnt_o <= '0;
      mispred_cnt_o  <= '0;
    end else if (pop) begin
      if (resolved_cnt_o != '1) begin
        resolved_cnt_o <= resolved_cnt_o + ctr_width_p'(1);
      end
      if (!correct && (mispred_cnt_o != '1)) begin
        mispred_cnt_o <= mispred_cnt_o + ctr_width_p'(1);
      end
    end
  end

endmodule

// File: tb/tb_bp_fe_bp_update_ctrl.sv
module tb_bp_fe_bp_update_ctrl;

  localparam int IW = 10;
  localparam int DEPTH = 8;
  localparam int CW = 4;
  localparam int CMAX = 15;

  typedef struct {
    logic [IW-1:0] idx;
    logic          bit1;  // pred for in-flight model, correct for expected writes
  } ent_t;

  logic clk = 1'b0;
  logic reset_i, fetch_v_i, bp_predict_i, resolve_v_i, resolve_taken_i, flush_i;
  logic [IW-1:0] fetch_idx_i;
  logic fetch_ready_o, fetch_taken_o, bp_r_v_o, resolve_ready_o;
  logic bp_w_v_o, bp_correct_o;
  logic [IW-1:0] bp_idx_r_o, bp_idx_w_o;
  logic [CW-1:0] resolved_cnt_o, mispred_cnt_o;

  int vectors = 0;
  int miscompares = 0;

  ent_t mq[$];      // model of in-flight queue
  ent_t expq[$];    // scoreboard of expected writes
  int m_res = 0;
  int m_mis = 0;

  always #5 clk = ~clk;

  bp_fe_bp_update_ctrl #(
    .bht_idx_width_p(IW),
    .depth_p(DEPTH),
    .ctr_width_p(CW)
  ) dut (
    .clk_i(clk), .reset_i(reset_i),
    .fetch_v_i(fetch_v_i), .fetch_idx_i(fetch_idx_i),
    .fetch_ready_o(fetch_ready_o), .fetch_taken_o(fetch_taken_o),
    .bp_r_v_o(bp_r_v_o), .bp_idx_r_o(bp_idx_r_o), .bp_predict_i(bp_predict_i),
    .resolve_v_i(resolve_v_i), .resolve_taken_i(resolve_taken_i),
    .resolve_ready_o(resolve_ready_o), .flush_i(flush_i),
    .bp_w_v_o(bp_w_v_o), .bp_idx_w_o(bp_idx_w_o), .bp_correct_o(bp_correct_o),
    .resolved_cnt_o(resolved_cnt_o), .mispred_cnt_o(mispred_cnt_o)
  );

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write the DUT presents must match the oldest expectation,
  // and every expectation must be met on the very next negedge.
  always @(negedge clk) begin
    if (bp_w_v_o) begin
      if (expq.size() == 0) begin
        chk("unexpected_write", 1, 0);
      end else begin
        ent_t e;
        e = expq.pop_front();
        chk("write_idx", int'(bp_idx_w_o), int'(e.idx));
        chk("write_correct", int'(bp_correct_o), int'(e.bit1));
      end
    end else if (expq.size() != 0) begin
      ent_t e;
      e = expq.pop_front();
      chk("missing_write", 0, 1);
    end
  end

  task automatic cycle(input bit fv, input int fidx, input bit pred,
                       input bit rv, input bit rt, input bit fl);
    bit push_ok, pop_ok;
    ent_t e, ne;
    fetch_v_i = fv; fetch_idx_i = fidx[IW-1:0]; bp_predict_i = pred;
    resolve_v_i = rv; resolve_taken_i = rt; flush_i = fl;
    push_ok = fv && (mq.size() < DEPTH) && !fl;
    pop_ok  = rv && (mq.size() > 0);
    #1;
    chk("fetch_ready", int'(fetch_ready_o), int'((mq.size() < DEPTH) && !fl));
    chk("resolve_ready", int'(resolve_ready_o), int'(mq.size() > 0));
    chk("fetch_taken", int'(fetch_taken_o), int'(pred));
    @(posedge clk);
    if (pop_ok) begin
      e = mq.pop_front();
      ne.idx = e.idx; ne.bit1 = (e.bit1 == rt);
      expq.push_back(ne);
      if (m_res < CMAX) m_res++;
      if (!ne.bit1 && m_mis < CMAX) m_mis++;
    end
    if (fl) mq.delete();
    else if (push_ok) begin
      ne.idx = fidx[IW-1:0]; ne.bit1 = pred;
      mq.push_back(ne);
    end
    #1;
    chk("resolved_cnt", int'(resolved_cnt_o), m_res);
    chk("mispred_cnt", int'(mispred_cnt_o), m_mis);
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    fetch_v_i = 0; resolve_v_i = 0; flush_i = 0;
    @(posedge clk);
    mq.delete(); expq.delete(); m_res = 0; m_mis = 0;
    #1;
    reset_i = 1'b0;
    chk("rst_w_v", int'(bp_w_v_o), 0);
    chk("rst_w_idx", int'(bp_idx_w_o), 0);
    chk("rst_correct", int'(bp_correct_o), 0);
    chk("rst_resolved", int'(resolved_cnt_o), 0);
    chk("rst_mispred", int'(mispred_cnt_o), 0);
    chk("rst_fetch_ready", int'(fetch_ready_o), 1);
    chk("rst_resolve_ready", int'(resolve_ready_o), 0);
  endtask

  initial begin
    reset_i = 1; fetch_v_i = 0; fetch_idx_i = '0; bp_predict_i = 0;
    resolve_v_i = 0; resolve_taken_i = 0; flush_i = 0;
    @(posedge clk);
    do_reset();

    // 1: single branch, mispredicted
    cycle(1, 5, 1, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 0);
    idle();
    chk("t1_mispred", int'(mispred_cnt_o), 1);

    // 2: fill to full, refused push, in-order retire
    for (int i = 0; i < DEPTH; i++) cycle(1, i, i % 2, 0, 0, 0);
    chk("t2_full_ready", int'(fetch_ready_o), 0);
    cycle(1, 99, 1, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 0);
    chk("t2_ready_after_pop", int'(fetch_ready_o), 1);
    for (int i = 1; i < DEPTH; i++) cycle(0, 0, 0, 1, (i % 3) == 0, 0);
    idle();

    // 3: full push+pop -> pop only; then mixed traffic around half-full
    for (int i = 0; i < DEPTH; i++) cycle(1, 200 + i, 1, 0, 0, 0);
    cycle(1, 300, 0, 1, 1, 0);
    chk("t3_occupancy", mq.size(), DEPTH - 1);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 20; i++)
      cycle((i % 3) != 2, 400 + i, i % 2, (i % 2) == 0, (i % 4) < 2, 0);
    while (mq.size() > 0) cycle(0, 0, 0, 1, 1, 0);
    idle();

    // 4: flush with concurrent resolve of head
    cycle(1, 11, 1, 0, 0, 0);
    cycle(1, 12, 0, 0, 0, 0);
    cycle(1, 13, 1, 0, 0, 0);
    cycle(1, 14, 1, 1, 1, 1);
    chk("t4_resolve_ready_after_flush", int'(resolve_ready_o), 0);
    idle();

    // 5: resolve while empty is ignored; reset mid-operation
    cycle(0, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 1, 1, 0);
    for (int i = 0; i < 4; i++) cycle(1, 50 + i, 0, 0, 0, 0);
    do_reset();
    idle();

    // 6: saturation of both counters
    for (int i = 0; i < 20; i++) begin
      cycle(1, 600 + i, 1, 0, 0, 0);
      cycle(0, 0, 0, 1, 0, 0);
    end
    idle();
    chk("t6_resolved_sat", int'(resolved_cnt_o), CMAX);
    chk("t6_mispred_sat", int'(mispred_cnt_o), CMAX);

    idle();
    chk("scoreboard_drained", expq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
